pending_priority_encoder: RTL and testbench

- Sequential 4-to-2 encoder; the inverse of the team's 2-to-4 one-hot decoder.
- Latches one-hot/multi-hot request pulses into a pending register.
- Presents the highest-priority pending index as a 2-bit code with a valid/ack handshake.
- Sits upstream of the decoder, so the code→decode round trip closes over a handshake instead of raw wires.

---
 rtl/ppe_pkg.sv | 16 +
 rtl/prio_enc4.sv | 22 ++
 rtl/pending_priority_encoder.sv | 93 +++++++++
 tb/tb_pending_priority_encoder.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/ppe_pkg.sv
// Shared widths and state encoding for the pending priority encoder.
//   N_IN       : number of request lines
//   CODE_W     : width of the encoded index
//   DROP_CNT_W : width of the optional merged-request counter
package ppe_pkg;

   localparam int unsigned N_IN       = 4;
   localparam int unsigned CODE_W     = 2;
   localparam int unsigned DROP_CNT_W = 8;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

endpackage

// File: rtl/prio_enc4.sv
// Combinational 4-input priority encoder, highest set index wins.
//   vec : input vector, bit i = index i
//   idx : index of the highest set bit (0 when vec is empty)
//   any : at least one bit of vec is set
module prio_enc4
   import ppe_pkg::*;
(
   input  logic [N_IN-1:0]   vec,
   output logic [CODE_W-1:0] idx,
   output logic              any
);

   always_comb begin
      idx = '0;
      any = |vec;
      if (vec[3])      idx = CODE_W'(3);
      else if (vec[2]) idx = CODE_W'(2);
      else if (vec[1]) idx = CODE_W'(1);
      else             idx = CODE_W'(0);
   end

endmodule

// File: rtl/pending_priority_encoder.sv
// Sequential 4-to-2 encoder: latches request pulses into a pending register
// and presents the highest pending index with a valid/ack handshake.
//   clk      : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   req      : request pulses, bit i = index i, multi-hot allowed
//   code     : encoded index of the granted request
//   valid    : code is valid and held stable until ack
//   ack      : consumer accepts code, only honoured while valid
//   pending  : current pending register
//   drop_cnt : saturating count of cycles in which a request merged into an
//              already-pending bit (only with PENDING_PRIORITY_ENCODER_DROP_CNT_EN)
module pending_priority_encoder
   import ppe_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [N_IN-1:0]       req,
   output logic [CODE_W-1:0]     code,
   output logic                  valid,
   input  logic                  ack,
   output logic [N_IN-1:0]       pending
`ifdef PENDING_PRIORITY_ENCODER_DROP_CNT_EN
   ,
   output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

   state_t            state;
   logic [N_IN-1:0]   clr_mask_c;
   logic [CODE_W-1:0] prio_idx;
   logic              prio_any;

   // Highest pending index, evaluated on the registered pending vector.
   prio_enc4 u_prio (
      .vec (pending),
      .idx (prio_idx),
      .any (prio_any)
   );

   // Bit to retire this cycle: the granted index once the consumer accepts it.
   always_comb begin
      clr_mask_c = '0;
      if (valid && ack) clr_mask_c = N_IN'(1) << code;
   end

   // Pending register; a new request on a bit being cleared re-sets it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) pending <= '0;
      else          pending <= (pending & ~clr_mask_c) | req;
   end

   // Grant FSM: IDLE picks the highest pending index, HOLD freezes it until ack.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         code  <= '0;
         valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (prio_any) begin
                  code  <= prio_idx;
                  valid <= 1'b1;
                  state <= HOLD;
               end
            end
            HOLD: begin
               if (ack) begin
                  valid <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               valid <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef PENDING_PRIORITY_ENCODER_DROP_CNT_EN
   logic merge_c;

   // A merge is a request landing on a bit that stays pending this cycle.
   assign merge_c = |(req & pending & ~clr_mask_c);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                             drop_cnt <= '0;
      else if (merge_c && (drop_cnt != '1))     drop_cnt <= drop_cnt + DROP_CNT_W'(1);
   end
`endif

endmodule

// File: tb/tb_pending_priority_encoder.sv
// Directed, table-driven bench for pending_priority_encoder.
module tb_pending_priority_encoder;

   logic       clk;
   logic       reset_n;
   logic [3:0] req;
   logic       ack;
   logic [1:0] code;
   logic       valid;
   logic [3:0] pending;
`ifdef PENDING_PRIORITY_ENCODER_DROP_CNT_EN
   logic [7:0] drop_cnt;
`endif

   int checks = 0;
   int errors = 0;

   pending_priority_encoder dut (
      .clk     (clk),
      .reset_n (reset_n),
      .req     (req),
      .code    (code),
      .valid   (valid),
      .ack     (ack),
      .pending (pending)
`ifdef PENDING_PRIORITY_ENCODER_DROP_CNT_EN
      ,
      .drop_cnt(drop_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] req;
      logic       ack;
      logic       valid;
      logic [1:0] code;
      logic [3:0] pending;
   } vec_t;

   localparam int NV = 29;
   vec_t tbl [NV];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_state(input string tag, input logic v, input logic [1:0] c,
                              input logic [3:0] p);
      check({tag, ".valid"},   8'(valid),   8'(v));
      check({tag, ".code"},    8'(code),    8'(c));
      check({tag, ".pending"}, 8'(pending), 8'(p));
   endtask

   initial begin
      // Expected values are the outputs right after the edge that samples req/ack.
      //              req      ack   valid code   pending
      tbl[0]  = '{4'b1111, 1'b0, 1'b0, 2'd0, 4'b1111};
      tbl[1]  = '{4'b0000, 1'b0, 1'b1, 2'd3, 4'b1111};
      tbl[2]  = '{4'b0000, 1'b1, 1'b0, 2'd3, 4'b0111};
      tbl[3]  = '{4'b0000, 1'b0, 1'b1, 2'd2, 4'b0111};
      tbl[4]  = '{4'b0000, 1'b1, 1'b0, 2'd2, 4'b0011};
      tbl[5]  = '{4'b0000, 1'b1, 1'b1, 2'd1, 4'b0011}; // ack while idle ignored
      tbl[6]  = '{4'b0000, 1'b1, 1'b0, 2'd1, 4'b0001};
      tbl[7]  = '{4'b0000, 1'b1, 1'b1, 2'd0, 4'b0001};
      tbl[8]  = '{4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000};
      tbl[9]  = '{4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000};
      // priority drain of 0101 with ack held high
      tbl[10] = '{4'b0101, 1'b1, 1'b0, 2'd0, 4'b0101};
      tbl[11] = '{4'b0000, 1'b1, 1'b1, 2'd2, 4'b0101};
      tbl[12] = '{4'b0000, 1'b1, 1'b0, 2'd2, 4'b0001};
      tbl[13] = '{4'b0000, 1'b1, 1'b1, 2'd0, 4'b0001};
      tbl[14] = '{4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000};
      // no pre-emption by a higher request while holding
      tbl[15] = '{4'b0001, 1'b0, 1'b0, 2'd0, 4'b0001};
      tbl[16] = '{4'b0000, 1'b0, 1'b1, 2'd0, 4'b0001};
      tbl[17] = '{4'b1000, 1'b0, 1'b1, 2'd0, 4'b1001};
      tbl[18] = '{4'b0000, 1'b0, 1'b1, 2'd0, 4'b1001};
      tbl[19] = '{4'b0000, 1'b1, 1'b0, 2'd0, 4'b1000};
      tbl[20] = '{4'b0000, 1'b0, 1'b1, 2'd3, 4'b1000};
      tbl[21] = '{4'b1000, 1'b0, 1'b1, 2'd3, 4'b1000}; // merge, no second grant
      // set-wins collision on bit 2
      tbl[22] = '{4'b0100, 1'b1, 1'b0, 2'd3, 4'b0100};
      tbl[23] = '{4'b0000, 1'b0, 1'b1, 2'd2, 4'b0100};
      tbl[24] = '{4'b0100, 1'b1, 1'b0, 2'd2, 4'b0100};
      tbl[25] = '{4'b0000, 1'b0, 1'b1, 2'd2, 4'b0100};
      tbl[26] = '{4'b0000, 1'b1, 1'b0, 2'd2, 4'b0000};
      // set up HOLD with pending 1010 for the mid-operation reset
      tbl[27] = '{4'b1010, 1'b0, 1'b0, 2'd2, 4'b1010};
      tbl[28] = '{4'b0000, 1'b0, 1'b1, 2'd3, 4'b1010};

      // reset with all requests asserted
      reset_n = 1'b0;
      req     = 4'b1111;
      ack     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_state("reset", 1'b0, 2'd0, 4'b0000);
`ifdef PENDING_PRIORITY_ENCODER_DROP_CNT_EN
      check("reset.drop_cnt", drop_cnt, 8'd0);
`endif
      @(negedge clk);
      reset_n = 1'b1;

      // idle with no requests keeps code at 0
      req = 4'b0000;
      repeat (4) @(posedge clk);
      #1;
      check_state("quiet", 1'b0, 2'd0, 4'b0000);

      for (int i = 0; i < NV; i++) begin
         req = tbl[i].req;
         ack = tbl[i].ack;
         @(posedge clk);
         #1;
         check_state($sformatf("vec%0d", i), tbl[i].valid, tbl[i].code, tbl[i].pending);
      end
      req = 4'b0000;
      ack = 1'b0;

`ifdef PENDING_PRIORITY_ENCODER_DROP_CNT_EN
      // only vec21 merged into a pending bit that was not being cleared
      check("table.drop_cnt", drop_cnt, 8'd1);
`endif

      // asynchronous reset between edges while holding
      #3;
      reset_n = 1'b0;
      #1;
      check_state("async_rst", 1'b0, 2'd0, 4'b0000);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      check_state("post_rst", 1'b0, 2'd0, 4'b0000);
      @(posedge clk);
      #1;
      check("post_rst2.valid", 8'(valid), 8'd0);

`ifdef PENDING_PRIORITY_ENCODER_DROP_CNT_EN
      check("post_rst.drop_cnt", drop_cnt, 8'd0);
      // 300 cycles of req=0001 without ack: 299 merging cycles, saturates at 255
      req = 4'b0001;
      repeat (300) @(posedge clk);
      #1;
      req = 4'b0000;
      check("sat.drop_cnt", drop_cnt, 8'd255);
      check_state("sat", 1'b1, 2'd0, 4'b0001);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
